key_debouncer: RTL and testbench

- Front-end conditioner for the board push-keys feeding the random-roll block's start input.
- Turns a raw, asynchronous, bouncing key into a clean debounced level plus single-cycle press/release pulses.
- o_pressed drives i_start of the roll logic; one physical press yields exactly one start pulse.
- Sits between the board pin and the control/roll logic, one instance per key.

---
 rtl/key_debouncer_pkg.sv | 15 +
 rtl/sync_ff.sv | 24 ++
 rtl/key_debouncer.sv | 153 +++++++++++++++
 tb/tb_key_debouncer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// Shared types and 50 MHz board defaults for the key debouncer.
package key_debouncer_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  localparam int HOLD_CYCLES_DEFAULT     = 25_000_000;
  localparam int REPEAT_CYCLES_DEFAULT   = 5_000_000;

  // The debounced level is high in both states that follow an accepted press.
  function automatic logic is_down(state_t s);
    return (s == HELD) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop chain that brings an asynchronous board input into the i_clk domain.
module sync_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stage_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/key_debouncer.sv
// Debounces one raw push-key into a clean level plus press/release pulses.
// Define KEY_DEBOUNCER_AUTOREPEAT_EN to add hold-to-repeat press pulses.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level,
  output logic o_pressed,
  output logic o_released
);

  localparam int             CNT_W        = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic           RAW_RELEASED = (KEY_ACTIVE_LOW != 0);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
      KEY_ACTIVE_LOW < 0 || KEY_ACTIVE_LOW > 1 || HOLD_CYCLES < 1 ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > HOLD_CYCLES) begin : g_bad_params
    $error("key_debouncer: illegal parameter combination");
  end

  logic             key_sync;
  logic             key_n;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, pressed_reg, released_reg;
  logic             repeat_hit;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (RAW_RELEASED)
  ) u_sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  (i_key),
    .o_q  (key_sync)
  );

  assign key_n = key_sync ^ RAW_RELEASED;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (key_n) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!key_n) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      HELD: begin
        if (!key_n) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (key_n) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RCNT_W = $clog2(HOLD_CYCLES + 1);

  logic [RCNT_W-1:0] rcnt_reg, rcnt_next, rcnt_target;
  logic              repeating_reg, repeating_next;

  // First target is the hold delay, then the repeat period; any exit from HELD restarts.
  always_comb begin
    rcnt_target    = repeating_reg ? RCNT_W'(REPEAT_CYCLES) : RCNT_W'(HOLD_CYCLES);
    repeat_hit     = 1'b0;
    rcnt_next      = '0;
    repeating_next = 1'b0;
    if (state_reg == HELD) begin
      repeating_next = repeating_reg;
      if (rcnt_reg == rcnt_target) begin
        repeat_hit     = 1'b1;
        rcnt_next      = RCNT_W'(1);
        repeating_next = 1'b1;
      end else begin
        rcnt_next = rcnt_reg + RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rcnt_reg      <= '0;
      repeating_reg <= 1'b0;
    end else begin
      rcnt_reg      <= rcnt_next;
      repeating_reg <= repeating_next;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // Outputs follow the state register by one cycle, so edges are detected against level_reg.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      level_reg    <= 1'b0;
      pressed_reg  <= 1'b0;
      released_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      level_reg    <= is_down(state_reg);
      pressed_reg  <= ((state_reg == HELD) && !level_reg) || repeat_hit;
      released_reg <= (state_reg == IDLE) && level_reg;
    end
  end

  assign o_level    = level_reg;
  assign o_pressed  = pressed_reg;
  assign o_released = released_reg;

endmodule

// File: tb/tb_key_debouncer.sv
// Randomised and directed bench for key_debouncer against a run-length reference model.
module tb_key_debouncer;

  localparam int SS   = 2;
  localparam int DB   = 8;
  localparam int HOLD = 20;
  localparam int REP  = 6;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_key = 1'b1;
  logic o_level, o_pressed, o_released;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  key_debouncer #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .KEY_ACTIVE_LOW (1),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_key     (i_key),
    .o_level   (o_level),
    .o_pressed (o_pressed),
    .o_released(o_released)
  );

  always #5 clk = ~clk;

  // Reference: the synced key must disagree with the accepted level for DB
  // consecutive cycles to flip it; outputs show the flip one cycle later.
  bit sync_m [SS];
  bit acc, pend_p, pend_r, model_valid;
  int run, h;
  bit exp_level, exp_p, exp_r;

  always @(posedge clk) begin
    bit synced, keyp, held_now, rep;
    cyc++;
    if (i_rst) begin
      for (int i = 0; i < SS; i++) sync_m[i] = 1'b1;
      acc = 0; run = 0; h = 0; pend_p = 0; pend_r = 0;
      exp_level = 0; exp_p = 0; exp_r = 0;
      model_valid = 1;
    end else begin
      synced = sync_m[SS-1];
      for (int i = SS - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
      sync_m[0] = i_key;
      keyp = !synced;
      held_now = acc && (run == 0);
      rep = 0;
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
      if (held_now) begin
        if (h >= HOLD && ((h - HOLD) % REP) == 0) rep = 1;
        h++;
      end else begin
        h = 0;
      end
`else
      h = held_now ? h + 1 : 0;
`endif
      exp_level = acc;
      exp_p = pend_p || rep;
      exp_r = pend_r;
      pend_p = 0;
      pend_r = 0;
      if (keyp != acc) begin
        run++;
        if (run == DB) begin
          acc = keyp;
          run = 0;
          pend_p = keyp;
          pend_r = !keyp;
        end
      end else begin
        run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      total++;
      if (o_level !== exp_level) begin
        bad++;
        $display("FAIL level cycle=%0d got=%b want=%b", cyc, o_level, exp_level);
      end
      total++;
      if (o_pressed !== exp_p) begin
        bad++;
        $display("FAIL pressed cycle=%0d got=%b want=%b", cyc, o_pressed, exp_p);
      end
      total++;
      if (o_released !== exp_r) begin
        bad++;
        $display("FAIL released cycle=%0d got=%b want=%b", cyc, o_released, exp_r);
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic measure(input int len, input bit sel_rel, output int first, output int count);
    first = -1;
    count = 0;
    for (int n = 1; n <= len; n++) begin
      step();
      if (sel_rel ? o_released : o_pressed) begin
        count++;
        if (first < 0) first = n;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, count, pc, rc, r, len;

    // Test 1: reset with key released, then idle.
    i_rst = 1'b1; i_key = 1'b1;
    repeat (3) step();
    check("reset_level", o_level, 0);
    check("reset_pressed", o_pressed, 0);
    check("reset_released", o_released, 0);
    i_rst = 1'b0;
    pc = 0; rc = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      pc += o_pressed; rc += o_released;
    end
    check("idle_pulses", pc + rc, 0);
    check("idle_level", o_level, 0);

    // Test 3: chatter every 3 cycles never qualifies.
    pc = 0; rc = 0;
    for (int n = 0; n < 52; n++) begin
      i_key = (n >= 40) ? 1'b1 : (((n / 3) % 2) == 0 ? 1'b0 : 1'b1);
      step();
      pc += o_pressed; rc += o_released;
    end
    check("bounce_pulses", pc + rc, 0);
    check("bounce_level", o_level, 0);

    // Test 2: clean press; first sampling edge is the next one.
    i_key = 1'b0;
    measure(11, 1'b0, first, count);
    check("press_latency", first, 11);
    check("press_count", count, 1);
    check("press_level", o_level, 1);
    repeat (19) step();
    check("held_level", o_level, 1);

    // Test 4: clean release.
    i_key = 1'b1;
    measure(11, 1'b1, first, count);
    check("release_latency", first, 11);
    check("release_count", count, 1);
    check("release_level", o_level, 0);
    repeat (5) step();

    // Test 5: reset in PRESS_WAIT at cnt=5 with key still low.
    i_key = 1'b0;
    measure(7, 1'b0, first, count);
    check("prewait_pulses", count, 0);
    i_rst = 1'b1;
    pc = 0;
    for (int n = 0; n < 2; n++) begin
      step();
      pc += o_pressed + o_released;
    end
    check("reset_mid_pulses", pc, 0);
    i_rst = 1'b0;
    measure(11, 1'b0, first, count);
    check("after_reset_latency", first, 11);
    check("after_reset_count", count, 1);

    // Test 6: long hold past the first pulse.
    measure(60, 1'b0, first, count);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    check("repeat_first", first, 20);
    check("repeat_count", count, 7);
`else
    check("repeat_first", first, -1);
    check("repeat_count", count, 0);
`endif
    i_key = 1'b1;
    repeat (15) step();
    check("final_release_level", o_level, 0);

    // Random segments, checked every cycle by the model.
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        i_rst = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        i_rst = 1'b0;
      end else begin
        i_key = 1'($urandom_range(0, 1));
        len = (r < 8) ? $urandom_range(30, 60) : $urandom_range(1, 14);
        repeat (len) step();
      end
    end
    i_key = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
